// File: rtl/loop_sequencer_pkg.sv
// Shared GPU ISA definitions used by decode and the loop sequencer:
// loop-control opcodes, loop-count width and sequencer state encoding.
package loop_sequencer_pkg;

  localparam int COUNT_WIDTH = 16;

  typedef logic [7:0]             opcode_t;
  typedef logic [COUNT_WIDTH-1:0] count_t;

  localparam opcode_t OP_STARTLOOP = 8'hC0;
  localparam opcode_t OP_ENDLOOP   = 8'hC8;
  localparam opcode_t OP_LOOPCOUNT = 8'hD1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } seq_state_t;

  // A loop count of zero still runs the body once.
  function automatic count_t normalize_count(input count_t raw);
    return (raw == '0) ? count_t'(1) : raw;
  endfunction

endpackage

// File: rtl/loop_stack.sv
// Hardware loop stack: each entry holds the loop-body start address and the
// remaining iteration count. Supports push, pop, decrement-top and clear.
module loop_stack
  import loop_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 4,
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  dec_top,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  count_t                push_count,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output count_t                top_count,
  output logic [LW-1:0]         level
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    count_t                count;
  } entry_t;

  entry_t          entries [DEPTH];
  logic [LW-1:0]   level_q;
  logic [IW-1:0]   top_idx;
  logic [IW-1:0]   push_idx;
  logic            do_push;
  logic            do_pop;
  logic            do_dec;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign top_idx  = IW'(level_q - LW'(1));
  assign push_idx = IW'(level_q);

  assign do_push = push    && !full  && !clear;
  assign do_pop  = pop     && !empty && !clear;
  assign do_dec  = dec_top && !empty && !clear;

  // NOTE: sequential state is assigned with <= so every flop samples values
  // from before the edge; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else if (clear) begin
      level_q <= '0;
    end else if (do_push) begin
      level_q <= level_q + LW'(1);
    end else if (do_pop) begin
      level_q <= level_q - LW'(1);
    end
  end

  // NOTE: entry storage is deliberately not reset; level_q alone decides which
  // entries are live, so clearing the level discards every stale entry.
  always_ff @(posedge clk) begin
    if (do_push) begin
      entries[push_idx] <= '{addr: push_addr, count: push_count};
    end else if (do_dec) begin
      entries[top_idx].count <= entries[top_idx].count - count_t'(1);
    end
  end

  assign top_addr  = entries[top_idx].addr;
  assign top_count = entries[top_idx].count;
  assign level     = level_q;

endmodule

// File: rtl/loop_sequencer.sv
// Instruction sequencer with zero-overhead hardware loops: fetches from PC,
// executes loop-control opcodes locally and forwards all others to decode.
module loop_sequencer
  import loop_sequencer_pkg::*;
#(
  parameter int PC_WIDTH    = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  input  logic                STALL,
  input  logic [PC_WIDTH-1:0] LAST_PC,
  input  logic [31:0]         INSTR,
  output logic [PC_WIDTH-1:0] PC,
  output logic                ISSUE_VALID,
  output logic [31:0]         ISSUE_INSTR,
  output logic [2:0]          LOOP_DEPTH,
  output logic                LOOP_ERR,
  output logic                DONE
);

  localparam int LW = $clog2(STACK_DEPTH + 1);

  seq_state_t          state;
  seq_state_t          state_next;

  logic [PC_WIDTH-1:0] pc_next;
  logic [PC_WIDTH-1:0] pc_inc;
  count_t              pending_q;
  count_t              pending_next;
  logic                valid_next;
  logic [31:0]         instr_next;
  logic                err_next;
  logic                err_set;
  logic                at_end;
  opcode_t             opcode;

  logic                stk_clear;
  logic                stk_push;
  logic                stk_pop;
  logic                stk_dec;
  logic                stk_full;
  logic                stk_empty;
  logic [PC_WIDTH-1:0] stk_top_addr;
  count_t              stk_top_count;
  logic [LW-1:0]       stk_level;

  assign opcode = INSTR[31:24];
  assign pc_inc = PC + PC_WIDTH'(1);

  loop_stack #(
    .ADDR_WIDTH (PC_WIDTH),
    .DEPTH      (STACK_DEPTH)
  ) u_loop_stack (
    .clk        (CLK),
    .reset      (RESET),
    .clear      (stk_clear),
    .push       (stk_push),
    .pop        (stk_pop),
    .dec_top    (stk_dec),
    .push_addr  (pc_inc),
    .push_count (pending_q),
    .full       (stk_full),
    .empty      (stk_empty),
    .top_addr   (stk_top_addr),
    .top_count  (stk_top_count),
    .level      (stk_level)
  );

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Instruction execution: next PC, pending count, issue and stack controls.
  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    pc_next      = PC;
    pending_next = pending_q;
    valid_next   = 1'b0;
    instr_next   = ISSUE_INSTR;
    err_next     = LOOP_ERR;
    err_set      = 1'b0;
    at_end       = 1'b0;
    stk_clear    = 1'b0;
    stk_push     = 1'b0;
    stk_pop      = 1'b0;
    stk_dec      = 1'b0;

    if (START) begin
      pc_next      = '0;
      pending_next = count_t'(1);
      err_next     = 1'b0;
      stk_clear    = 1'b1;
    end else if (state == ST_RUN && !STALL) begin
      at_end = (PC == LAST_PC);
      case (opcode)
        OP_LOOPCOUNT: begin
          pending_next = normalize_count(INSTR[15:0]);
          pc_next      = pc_inc;
        end
        OP_STARTLOOP: begin
          if (stk_full) begin
            err_set = 1'b1;
          end else begin
            stk_push     = 1'b1;
            pending_next = count_t'(1);
            pc_next      = pc_inc;
          end
        end
        OP_ENDLOOP: begin
          if (stk_empty) begin
            err_set = 1'b1;
          end else if (stk_top_count > count_t'(1)) begin
            // Taken branch back to the body never ends the program.
            stk_dec = 1'b1;
            pc_next = stk_top_addr;
            at_end  = 1'b0;
          end else begin
            stk_pop = 1'b1;
            pc_next = pc_inc;
          end
        end
        default: begin
          valid_next = 1'b1;
          instr_next = INSTR;
          pc_next    = pc_inc;
        end
      endcase
      if (err_set) begin
        err_next = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    if (START) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN:  if (err_set || at_end) state_next = ST_HALT;
        ST_IDLE: state_next = ST_IDLE;
        ST_HALT: state_next = ST_HALT;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    DONE       = (state == ST_HALT);
    LOOP_DEPTH = 3'(stk_level);
  end

  // Datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PC          <= '0;
      pending_q   <= count_t'(1);
      ISSUE_VALID <= 1'b0;
      ISSUE_INSTR <= '0;
      LOOP_ERR    <= 1'b0;
    end else begin
      PC          <= pc_next;
      pending_q   <= pending_next;
      ISSUE_VALID <= valid_next;
      ISSUE_INSTR <= instr_next;
      LOOP_ERR    <= err_next;
    end
  end

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed self-checking bench for loop_sequencer: linear programs, single and
// nested loops, stack overflow/underflow, stall, restart and mid-loop reset.
module tb_loop_sequencer;
  import loop_sequencer_pkg::*;

  localparam int PCW = 16;

  logic           CLK = 1'b0;
  logic           RESET;
  logic           START;
  logic           STALL;
  logic [PCW-1:0] LAST_PC;
  logic [31:0]    INSTR;
  logic [PCW-1:0] PC;
  logic           ISSUE_VALID;
  logic [31:0]    ISSUE_INSTR;
  logic [2:0]     LOOP_DEPTH;
  logic           LOOP_ERR;
  logic           DONE;

  logic [31:0] mem [16];
  logic [31:0] issued [$];
  int          depths [$];
  int          max_depth;
  int          checks   = 0;
  int          failures = 0;

  localparam logic [31:0] I_SL = 32'hC000_0000;
  localparam logic [31:0] I_EL = 32'hC800_0000;
  localparam logic [31:0] I_A  = 32'h2000_00A1;
  localparam logic [31:0] I_B  = 32'h2100_00B2;

  always #5 CLK = ~CLK;

  assign INSTR = mem[PC[3:0]];

  loop_sequencer #(.PC_WIDTH(PCW), .STACK_DEPTH(4)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .START       (START),
    .STALL       (STALL),
    .LAST_PC     (LAST_PC),
    .INSTR       (INSTR),
    .PC          (PC),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_INSTR (ISSUE_INSTR),
    .LOOP_DEPTH  (LOOP_DEPTH),
    .LOOP_ERR    (LOOP_ERR),
    .DONE        (DONE)
  );

  function automatic logic [31:0] lc(input logic [15:0] n);
    return {8'hD1, 8'h00, n};
  endfunction

  function automatic logic [31:0] lin(input int k);
    return 32'h1000_0000 | 32'(k);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // Runs until DONE, logging every issued instruction and its loop depth.
  task automatic collect(input int budget);
    issued.delete();
    depths.delete();
    max_depth = 0;
    for (int c = 0; c < budget; c++) begin
      step();
      if (ISSUE_VALID) begin
        issued.push_back(ISSUE_INSTR);
        depths.push_back(int'(LOOP_DEPTH));
      end
      if (int'(LOOP_DEPTH) > max_depth) max_depth = int'(LOOP_DEPTH);
      if (DONE) return;
    end
    check("done_timeout", DONE, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; START = 1'b0; STALL = 1'b0; LAST_PC = '0;
    clear_mem();
    #2;
    check("rst_pc",    PC, 0);
    check("rst_valid", ISSUE_VALID, 0);
    check("rst_instr", ISSUE_INSTR, 0);
    check("rst_depth", LOOP_DEPTH, 0);
    check("rst_err",   LOOP_ERR, 0);
    check("rst_done",  DONE, 0);
    step(); step();
    RESET = 1'b0;
    step(); step();
    check("idle_pc",    PC, 0);
    check("idle_valid", ISSUE_VALID, 0);
    check("idle_done",  DONE, 0);

    // Linear program of four instructions, DONE on the fifth cycle.
    for (int k = 0; k < 4; k++) mem[k] = lin(k);
    LAST_PC = 3;
    pulse_start();
    check("lin_start_pc",    PC, 0);
    check("lin_start_valid", ISSUE_VALID, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("lin_valid_%0d", k), ISSUE_VALID, 1);
      check($sformatf("lin_instr_%0d", k), ISSUE_INSTR, lin(k));
      check($sformatf("lin_done_%0d", k), DONE, (k == 3) ? 1 : 0);
    end
    step();
    check("lin_halt_valid", ISSUE_VALID, 0);
    check("lin_halt_done",  DONE, 1);

    // START while running restarts from PC 0.
    pulse_start();
    step(); step();
    pulse_start();
    check("restart_pc",    PC, 0);
    check("restart_valid", ISSUE_VALID, 0);
    check("restart_done",  DONE, 0);
    collect(20);
    check("restart_count", issued.size(), 4);
    for (int k = 0; k < 4 && k < issued.size(); k++)
      check($sformatf("restart_instr_%0d", k), issued[k], lin(k));

    // LOOPCOUNT 3; STARTLOOP; A; ENDLOOP.
    clear_mem();
    mem[0] = lc(16'd3); mem[1] = I_SL; mem[2] = I_A; mem[3] = I_EL;
    LAST_PC = 3;
    pulse_start();
    collect(40);
    check("loop3_count", issued.size(), 3);
    for (int k = 0; k < 3 && k < issued.size(); k++) begin
      check($sformatf("loop3_instr_%0d", k), issued[k], I_A);
      check($sformatf("loop3_depth_%0d", k), depths[k], 1);
    end
    check("loop3_final_depth", LOOP_DEPTH, 0);
    check("loop3_err",         LOOP_ERR, 0);

    // Count 0 behaves as 1.
    mem[0] = lc(16'd0);
    pulse_start();
    collect(40);
    check("loop0_count", issued.size(), 1);

    // Nested 2 x 3 around B; the outer ENDLOOP branches at LAST_PC.
    clear_mem();
    mem[0] = lc(16'd2); mem[1] = I_SL; mem[2] = lc(16'd3); mem[3] = I_SL;
    mem[4] = I_B; mem[5] = I_EL; mem[6] = I_EL;
    LAST_PC = 6;
    pulse_start();
    collect(80);
    check("nest_count", issued.size(), 6);
    for (int k = 0; k < 6 && k < issued.size(); k++)
      check($sformatf("nest_instr_%0d", k), issued[k], I_B);
    check("nest_max_depth",   max_depth, 2);
    check("nest_final_depth", LOOP_DEPTH, 0);
    check("nest_done",        DONE, 1);

    // Five nested STARTLOOPs overflow a four-deep stack.
    clear_mem();
    for (int k = 0; k < 5; k++) mem[k] = I_SL;
    mem[5] = I_A;
    LAST_PC = 5;
    pulse_start();
    collect(20);
    check("ovf_err",    LOOP_ERR, 1);
    check("ovf_done",   DONE, 1);
    check("ovf_depth",  LOOP_DEPTH, 4);
    check("ovf_issued", issued.size(), 0);
    step();
    check("ovf_depth_hold", LOOP_DEPTH, 4);

    // ENDLOOP on empty stack underflows; START first clears error and stack.
    clear_mem();
    mem[0] = I_EL;
    LAST_PC = 3;
    pulse_start();
    check("unf_start_err",   LOOP_ERR, 0);
    check("unf_start_depth", LOOP_DEPTH, 0);
    collect(20);
    check("unf_err",    LOOP_ERR, 1);
    check("unf_done",   DONE, 1);
    check("unf_depth",  LOOP_DEPTH, 0);
    check("unf_issued", issued.size(), 0);

    // STALL for three cycles inside the loop body.
    clear_mem();
    mem[0] = lc(16'd3); mem[1] = I_SL; mem[2] = I_A; mem[3] = I_B; mem[4] = I_EL;
    LAST_PC = 4;
    pulse_start();
    step(); step(); step();
    check("stall_pre_valid", ISSUE_VALID, 1);
    check("stall_pre_instr", ISSUE_INSTR, I_A);
    check("stall_pre_pc",    PC, 3);
    STALL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("stall_pc_%0d", k),    PC, 3);
      check($sformatf("stall_valid_%0d", k), ISSUE_VALID, 0);
      check($sformatf("stall_instr_%0d", k), ISSUE_INSTR, I_A);
    end
    STALL = 1'b0;
    collect(40);
    check("stall_count", issued.size(), 5);
    for (int k = 0; k < 5 && k < issued.size(); k++)
      check($sformatf("stall_order_%0d", k), issued[k], (k % 2 == 0) ? I_B : I_A);

    // RESET during the second iteration of a count-5 loop.
    clear_mem();
    mem[0] = lc(16'd5); mem[1] = I_SL; mem[2] = I_A; mem[3] = I_EL;
    LAST_PC = 3;
    pulse_start();
    for (int k = 0; k < 5; k++) step();
    check("mid_valid", ISSUE_VALID, 1);
    check("mid_depth", LOOP_DEPTH, 1);
    #2;
    RESET = 1'b1;
    #1;
    check("mrst_pc",    PC, 0);
    check("mrst_valid", ISSUE_VALID, 0);
    check("mrst_instr", ISSUE_INSTR, 0);
    check("mrst_depth", LOOP_DEPTH, 0);
    check("mrst_err",   LOOP_ERR, 0);
    check("mrst_done",  DONE, 0);
    step();
    RESET = 1'b0;
    step(); step();
    check("mrst_idle_pc",    PC, 0);
    check("mrst_idle_valid", ISSUE_VALID, 0);
    check("mrst_idle_done",  DONE, 0);
    pulse_start();
    collect(60);
    check("mrst_rerun_count", issued.size(), 5);
    check("mrst_rerun_depth", LOOP_DEPTH, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/loop_sequencer.md
LOOP_SEQUENCER -- requirements
Module: loop_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 16, width of the program counter.
REQ-002 Parameter STACK_DEPTH, default 4, number of nested loop levels.
REQ-003 CLK  input  1  clock; all state updates on posedge.
REQ-004 RESET  input  1  reset, asynchronous, active-high.
REQ-005 START  input  1  one-cycle pulse that begins execution at PC 0.
REQ-006 STALL  input  1  downstream hold; freezes all sequencer state.
REQ-007 LAST_PC  input  PC_WIDTH  address of the final program instruction.
REQ-008 INSTR  input  32  instruction memory data at PC, combinational from memory.
REQ-009 PC  output  PC_WIDTH  registered fetch address.
REQ-010 ISSUE_VALID  output  1  registered; ISSUE_INSTR is valid for decode.
REQ-011 ISSUE_INSTR  output  32  registered instruction forwarded to decode.
REQ-012 LOOP_DEPTH  output  3  current stack occupancy, 0..STACK_DEPTH.
REQ-013 LOOP_ERR  output  1  sticky error flag for stack overflow or underflow.
REQ-014 DONE  output  1  high while in the HALT state.

Function
REQ-015 FSM states SHALL be IDLE, RUN and HALT, with these transitions:
- IDLE->RUN on START.
- RUN->HALT after processing PC==LAST_PC with no loop branch taken, or on LOOP_ERR being set.
- HALT->RUN on START.
REQ-016 START SHALL set PC=0, empty the stack, clear the pending count to 1, and clear LOOP_ERR.
REQ-017 In RUN with STALL=0, one instruction SHALL be processed per cycle; opcode = INSTR[31:24].
REQ-018 LOOPCOUNT (8'hD1) SHALL load pending count = INSTR[15:0], with value 0 treated as 1; PC+1; not issued.
REQ-019 STARTLOOP (8'hC0) SHALL push {PC+1, pending count}, reset pending count to 1, PC+1; not issued.
REQ-020 ENDLOOP (8'hC8) with top count >1 SHALL decrement the top count and set PC=top start address; not issued.
REQ-021 ENDLOOP with top count ==1 SHALL pop the stack and set PC+1; not issued.
REQ-022 Any other opcode SHALL be registered into ISSUE_INSTR with ISSUE_VALID=1 the next cycle, and PC+1.
REQ-023 ISSUE_VALID SHALL be 0 in every cycle after a non-issued, stalled, IDLE or HALT cycle.
REQ-024 STALL=1 SHALL hold PC, stack, pending count, state and ISSUE_INSTR, and force ISSUE_VALID to 0 next cycle.
REQ-025 STARTLOOP with a full stack SHALL set LOOP_ERR, leave the stack unchanged, and go to HALT.
REQ-026 ENDLOOP with an empty stack SHALL set LOOP_ERR, leave the stack unchanged, and go to HALT.
REQ-027 PC arithmetic SHALL be modulo 2^PC_WIDTH; wrap from all-ones to 0 is not an error.
REQ-028 ENDLOOP that branches at PC==LAST_PC SHALL NOT halt; HALT is entered only on fall-through.
REQ-029 START asserted in RUN SHALL restart exactly as REQ-016.
REQ-030 Loop counts SHALL be 16-bit unsigned; a count of N executes the body N times.

Reset
REQ-031 RESET SHALL immediately force state IDLE, PC=0, stack empty, pending count=1, ISSUE_VALID=0, ISSUE_INSTR=0, LOOP_DEPTH=0, LOOP_ERR=0 and DONE=0.
REQ-032 RESET asserted mid-loop SHALL discard all stack contents; no partial iteration state survives.

Structure
REQ-033 Opcode constants (STARTLOOP, ENDLOOP, LOOPCOUNT) SHALL live in the shared GPU ISA package used by ID.
REQ-034 The loop stack SHALL be the sub-module loop_stack, which has:
- push, pop and decrement-top ports;
- full/empty flags;
- a top-of-stack read port.
REQ-035 The FSM and PC logic SHALL stay in loop_sequencer.

Verification
REQ-036 Linear program, LAST_PC=3, no loop ops, START: the four instructions are issued in order, then DONE=1 at cycle 5.
REQ-037 Program LOOPCOUNT 3; STARTLOOP; A; ENDLOOP: A is issued exactly 3 times, LOOP_DEPTH sequence 1,1,1,0, then HALT.
REQ-038 Nested loops with counts 2 and 3 around body B: B is issued 6 times and the maximum LOOP_DEPTH is 2.
REQ-039 Five nested STARTLOOPs with STACK_DEPTH=4: LOOP_ERR=1 after the fifth, DONE=1, and LOOP_DEPTH stays 4.
REQ-040 STALL held 3 cycles mid-body: PC is frozen, ISSUE_VALID=0 for 3 cycles, and the issue order is unchanged.
REQ-041 RESET pulsed during the 2nd iteration of a count-5 loop: all outputs return to reset values at once, and the state is IDLE.
